// File: rtl/gmii_rx_pkg.sv
// ============================================================================
// gmii_rx_pkg : shared types and constants for the GMII receive framer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package gmii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int LEN_W = 12;
  localparam int CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/gmii_rx_delay_line.sv
// ============================================================================
// gmii_rx_delay_line : DEPTH-deep byte shift register with occupancy tracking
// Revision           : 1.0
// ============================================================================
`default_nettype none

module gmii_rx_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    sr [DEPTH];
  logic [CW-1:0] count;

  // Newest byte enters at index 0; the oldest sits at DEPTH-1 once full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) sr[i] <= 8'h00;
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      if (!full) count <= count + CW'(1);
    end
  end

  assign head = sr[DEPTH-1];
  assign full = (count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/gmii_rx_frame_parser.sv
// ============================================================================
// gmii_rx_frame_parser : GMII preamble/SFD checker and frame body framer.
// Optional FCS hold-back enabled by defining GMII_RX_FCS_STRIP_EN.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module gmii_rx_frame_parser
  import gmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int PRE_MAX = 15
) (
  input  logic             i_gmii_rxclk,
  input  logic             i_gmii_rst,
  input  logic             i_gmii_dv,
  input  logic             i_gmii_er,
  input  logic [7:0]       iv_gmii_rxd,
  output logic             o_data_wr,
  output logic [7:0]       ov_data,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_err,
  output logic [LEN_W-1:0] ov_frame_len,
  output logic [CNT_W-1:0] ov_good_cnt,
  output logic [CNT_W-1:0] ov_err_cnt
);

`ifdef GMII_RX_FCS_STRIP_EN
  localparam int LOOKAHEAD = 4;
`else
  localparam int LOOKAHEAD = 0;
`endif

  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [7:0]       PRE_LIM = 8'(PRE_MAX);

  rx_state_t        state;
  logic             in_dv, in_er;
  logic [7:0]       in_rxd;
  logic [7:0]       pre_cnt;
  logic [LEN_W-1:0] len;
  logic             sticky_er;
  logic             sof_pend;

  logic       dl_push, dl_clear, dl_full;
  logic [7:0] dl_head;
  logic [7:0] pre_nxt;
  logic       frame_bad;

  assign dl_push   = (state == DATA) && in_dv;
  assign dl_clear  = (state == DATA) && !in_dv;
  assign pre_nxt   = pre_cnt + 8'd1;
  assign frame_bad = sticky_er || (len < MIN_L) || (len > MAX_L);

  gmii_rx_delay_line #(
    .DEPTH (LOOKAHEAD + 1)
  ) u_delay_line (
    .clk   (i_gmii_rxclk),
    .rst   (i_gmii_rst),
    .clear (dl_clear),
    .push  (dl_push),
    .din   (in_rxd),
    .head  (dl_head),
    .full  (dl_full)
  );

  always_ff @(posedge i_gmii_rxclk or posedge i_gmii_rst) begin
    if (i_gmii_rst) begin
      in_dv        <= 1'b0;
      in_er        <= 1'b0;
      in_rxd       <= 8'h00;
      state        <= IDLE;
      pre_cnt      <= 8'd0;
      len          <= '0;
      sticky_er    <= 1'b0;
      sof_pend     <= 1'b0;
      o_data_wr    <= 1'b0;
      ov_data      <= 8'h00;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_err        <= 1'b0;
      ov_frame_len <= '0;
      ov_good_cnt  <= '0;
      ov_err_cnt   <= '0;
    end else begin
      in_dv        <= i_gmii_dv;
      in_er        <= i_gmii_er;
      in_rxd       <= iv_gmii_rxd;
      o_data_wr    <= 1'b0;
      ov_data      <= 8'h00;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_err        <= 1'b0;
      ov_frame_len <= '0;

      case (state)
        IDLE: begin
          if (in_dv) begin
            if (in_rxd == PREAMBLE_BYTE) begin
              state   <= PRE;
              pre_cnt <= 8'd1;
            end else if (in_rxd == SFD_BYTE) begin
              state     <= DATA;
              len       <= '0;
              sticky_er <= 1'b0;
              sof_pend  <= 1'b1;
            end else begin
              state      <= DROP;
              ov_err_cnt <= ov_err_cnt + CNT_W'(1);
            end
          end
        end

        PRE: begin
          if (!in_dv) begin
            state <= IDLE;
          end else if (in_er) begin
            state      <= DROP;
            ov_err_cnt <= ov_err_cnt + CNT_W'(1);
          end else if (in_rxd == PREAMBLE_BYTE) begin
            pre_cnt <= pre_nxt;
            if (pre_nxt > PRE_LIM) begin
              state      <= DROP;
              ov_err_cnt <= ov_err_cnt + CNT_W'(1);
            end
          end else if (in_rxd == SFD_BYTE) begin
            state     <= DATA;
            len       <= '0;
            sticky_er <= 1'b0;
            sof_pend  <= 1'b1;
          end else begin
            state      <= DROP;
            ov_err_cnt <= ov_err_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (in_dv) begin
            if (len != {LEN_W{1'b1}}) len <= len + LEN_W'(1);
            if (in_er) sticky_er <= 1'b1;
            if (dl_full) begin
              o_data_wr <= 1'b1;
              ov_data   <= dl_head;
              o_sof     <= sof_pend;
              sof_pend  <= 1'b0;
            end
          end else begin
            // dv has fallen: len already holds the final count.
            state        <= IDLE;
            o_data_wr    <= 1'b1;
            o_sof        <= sof_pend;
            o_eof        <= 1'b1;
            ov_frame_len <= len;
            sof_pend     <= 1'b0;
            if (!dl_full) begin
              o_err      <= 1'b1;
              ov_err_cnt <= ov_err_cnt + CNT_W'(1);
            end else begin
              ov_data <= dl_head;
              o_err   <= frame_bad;
              if (frame_bad) ov_err_cnt  <= ov_err_cnt + CNT_W'(1);
              else           ov_good_cnt <= ov_good_cnt + CNT_W'(1);
            end
          end
        end

        DROP: begin
          if (!in_dv) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gmii_rx_frame_parser.sv
// ============================================================================
// tb_gmii_rx_frame_parser : scoreboard bench for the GMII receive framer
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_gmii_rx_frame_parser;

`ifdef GMII_RX_FCS_STRIP_EN
  localparam int L = 4;
`else
  localparam int L = 0;
`endif
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1522;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv  = 1'b0;
  logic        er  = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        data_wr, sof, eof, err;
  logic [7:0]  data;
  logic [11:0] frame_len;
  logic [15:0] good_cnt, err_cnt;

  gmii_rx_frame_parser #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN),
    .PRE_MAX (15)
  ) dut (
    .i_gmii_rxclk (clk),
    .i_gmii_rst   (rst),
    .i_gmii_dv    (dv),
    .i_gmii_er    (er),
    .iv_gmii_rxd  (rxd),
    .o_data_wr    (data_wr),
    .ov_data      (data),
    .o_sof        (sof),
    .o_eof        (eof),
    .o_err        (err),
    .ov_frame_len (frame_len),
    .ov_good_cnt  (good_cnt),
    .ov_err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic        err;
    logic [11:0] len;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    exp_good = 0;
  int    exp_err  = 0;
  bit    mon_en = 1'b1;

  // Monitor: every emitted beat is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && data_wr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected beat data=%02h sof=%0b eof=%0b, required no beat",
                 data, sof, eof);
      end else begin
        mon_e = sb.pop_front();
        if (data !== mon_e.d || sof !== mon_e.sof || eof !== mon_e.eof ||
            (mon_e.eof && (err !== mon_e.err || frame_len !== mon_e.len))) begin
          errors++;
          $display("FAIL beat: got d=%02h sof=%0b eof=%0b err=%0b len=%0d, required d=%02h sof=%0b eof=%0b err=%0b len=%0d",
                   data, sof, eof, err, frame_len,
                   mon_e.d, mon_e.sof, mon_e.eof, mon_e.err, mon_e.len);
        end
      end
    end
  end

  function automatic void expect_frame(input int n, input bit had_er);
    beat_t b;
    bit    bad;
    int    last;
    logic [11:0] ln;
    bad  = had_er || (n < MIN_LEN) || (n > MAX_LEN);
    ln   = (n > 4095) ? 12'd4095 : 12'(n);
    if (n <= L) begin
      b.d = 8'h00; b.sof = 1'b1; b.eof = 1'b1; b.err = 1'b1; b.len = ln;
      sb.push_back(b);
      exp_err++;
    end else begin
      last = n - 1 - L;
      for (int k = 0; k <= last; k++) begin
        b.d   = 8'(k);
        b.sof = (k == 0);
        b.eof = (k == last);
        b.err = (k == last) ? bad : 1'b0;
        b.len = (k == last) ? ln : 12'd0;
        sb.push_back(b);
      end
      if (bad) exp_err++;
      else     exp_good++;
    end
  endfunction

  task automatic drive(input logic [7:0] b, input logic e);
    @(posedge clk); #1;
    dv = 1'b1; rxd = b; er = e;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dv = 1'b0; er = 1'b0; rxd = 8'h00;
    end
  endtask

  // Preamble, SFD, n body bytes (value = index), then one dv=0 cycle.
  task automatic frame(input int npre, input int n, input int er_idx);
    expect_frame(n, er_idx >= 0 && er_idx < n);
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < n; i++) drive(8'(i), i == er_idx);
    gap(1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d beats outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_cnt(input string name);
    checks++;
    if (good_cnt !== 16'(exp_good) || err_cnt !== 16'(exp_err)) begin
      errors++;
      $display("FAIL %s counters: good=%0d err=%0d, required good=%0d err=%0d",
               name, good_cnt, err_cnt, exp_good, exp_err);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (data_wr !== 1'b0 || data !== 8'h00 || sof !== 1'b0 || eof !== 1'b0 ||
        err !== 1'b0 || frame_len !== 12'd0 || good_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s outputs: wr=%0b d=%02h sof=%0b eof=%0b err=%0b len=%0d good=%0d errc=%0d, required all 0",
               name, data_wr, data, sof, eof, err, frame_len, good_cnt, err_cnt);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    gap(2);

    frame(7, 64, -1);
    wait_drain("good64");
    check_cnt("good64");

    frame(7, 64, 10);
    wait_drain("er64");
    check_cnt("er64");

    drive(8'h55, 1'b0);
    drive(8'h54, 1'b0);
    gap(2);
    exp_err++;
    wait_drain("badpre");
    check_cnt("badpre");

    for (int i = 0; i < 16; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h01, 1'b0);
    gap(2);
    exp_err++;
    wait_drain("longpre");
    check_cnt("longpre");

    frame(15, 64, -1);
    wait_drain("pre15");
    check_cnt("pre15");

    frame(0, 64, -1);
    wait_drain("nopre");
    check_cnt("nopre");

    frame(7, 3, -1);
    wait_drain("runt");
    check_cnt("runt");

    frame(7, 1600, -1);
    wait_drain("giant");
    check_cnt("giant");

    frame(7, 64, -1);
    frame(7, 64, -1);
    wait_drain("b2b");
    check_cnt("b2b");

    // Mid-frame reset: partial frame vanishes, remaining body lands in DROP.
    gap(2);
    mon_en = 1'b0;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < 64; i++) begin
      drive(8'(i), 1'b0);
      if (i == 30) begin
        rst = 1'b1;
        #1;
        check_zero("midreset");
      end
      if (i == 33) rst = 1'b0;
    end
    gap(3);
    mon_en   = 1'b1;
    exp_good = 0;
    exp_err  = 1;
    check_cnt("postreset");

    frame(7, 64, -1);
    wait_drain("clean");
    check_cnt("clean");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
